cipher: RTL and testbench
=========================

# cipher

Iterative TEA (Tiny Encryption Algorithm) encryption core. It encrypts one 64-bit block, presented as two WORD_SIZE words, under a 128-bit key given as four words. It computes one full TEA cycle per clock and flags completion. It is a standalone datapath block that starts automatically after reset, with no start/valid handshake.

## Interface
- WORD_SIZE, default 32: width of every data and key word; all arithmetic is modulo 2^WORD_SIZE.
- DELTA, default 32'h9e3779b9: key-schedule constant added to the running sum each cycle.
- ROUND_NUMBER, default 32: number of TEA cycles; each cycle updates both halves. Must be ≥ 1.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; also loads the block and key.
- iV0  in  WORD_SIZE  plaintext word 0 (high half of block).
- iV1  in  WORD_SIZE  plaintext word 1 (low half).
- iK0..iK3  in  WORD_SIZE each  key words 0..3.
- oC0  out  WORD_SIZE  ciphertext word 0 (registered).
- oC1  out  WORD_SIZE  ciphertext word 1 (registered).
- oDone  out  1  high when oC0/oC1 hold the final ciphertext; sticky until reset.

## Operation
- Internal registers:
  - v0, v1 (working block)
  - k0..k3 (latched key)
  - sum (WORD_SIZE)
  - round counter, at least $clog2(ROUND_NUMBER+1) bits
  - state: RUN / DONE
- On reset (rst=1 at a rising edge):
  - v0←iV0, v1←iV1, k0..k3←iK0..iK3
  - sum←0, counter←0, state←RUN
  - oC0←0, oC1←0, oDone←0
- Inputs are sampled only during reset; changes afterwards are ignored until the next reset.
- RUN, each edge with rst=0, computed combinationally within the same cycle:
  - s' = sum + DELTA
  - v0' = v0 + (((v1<<4)+k0) ^ (v1+s') ^ ((v1>>5)+k1))
  - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+s') ^ ((v0'>>5)+k3)). v1' uses the new v0'.
  - Shifts are logical. Every add wraps modulo 2^WORD_SIZE.
  - Register sum←s', v0←v0', v1←v1', counter←counter+1.
- RUN→DONE when counter == ROUND_NUMBER-1 at the edge. On that same edge: oC0←v0', oC1←v1', oDone←1.
- DONE: all registers hold; oDone stays 1; outputs are stable indefinitely.
- There is no decrypt mode.

## Timing
- Let edge 0 be the last rising edge with rst=1.
- Cycles are performed on edges 1..ROUND_NUMBER.
- oDone and oC0/oC1 become valid right after edge ROUND_NUMBER. With the default, that is 32 clocks after reset release.
- Before that edge: oC0=oC1=0 and oDone=0. No partial results are visible.
- Reset mid-operation (RUN or DONE): the next edge restarts from the new inputs with all outputs cleared. There is no residual state.
- rst held high for multiple cycles: the block keeps reloading and does not advance.
- Throughput: one block per ROUND_NUMBER+1 cycles, counting one reset cycle.

## Test plan
- Zero test, defaults: iV0=iV1=0, all keys 0, pulse rst. Required: oDone rises exactly 32 clocks after rst falls; {oC0,oC1}=64'h41ea3a0a_94baa940.
- Single cycle: ROUND_NUMBER=1, zero block and key. Required: after one edge, oC0=32'h9e3779b9, oC1=32'hdbe8d32f, oDone=1.
- Random vectors, defaults: e.g. key 132acf42/234acb45/3235acbe/4533f235, block 3d45f7a7/235fcb21. Required: output equals a C TEA reference model; oDone stays 1 and outputs stay stable for ≥400 further cycles.
- Input isolation: change iV0/iV1/iK* after reset release. Required: result is identical to the unchanged-input run.
- Mid-run reset: assert rst at cycle 10, then release. Required: oC0=oC1=0 and oDone=0 on the reset edge; completion occurs 32 clocks after the new release, with a correct result for the new inputs.
- Reset while DONE: assert rst. Required: oDone and the outputs clear on the next edge.

Source files
------------

// File: rtl/cipher.sv
// Iterative TEA encryption core: one full TEA cycle (both halves) per clock.
// Loads block and key while rst is high, then runs ROUND_NUMBER cycles and
// presents the ciphertext with a sticky done flag until the next reset.
module cipher #(
    parameter int unsigned           WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0]  DELTA        = WORD_SIZE'(32'h9e3779b9),
    parameter int unsigned           ROUND_NUMBER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  iV0,
    input  logic [WORD_SIZE-1:0]  iV1,
    input  logic [WORD_SIZE-1:0]  iK0,
    input  logic [WORD_SIZE-1:0]  iK1,
    input  logic [WORD_SIZE-1:0]  iK2,
    input  logic [WORD_SIZE-1:0]  iK3,
    output logic [WORD_SIZE-1:0]  oC0,
    output logic [WORD_SIZE-1:0]  oC1,
    output logic                  oDone
);

    localparam int unsigned CNT_W = $clog2(ROUND_NUMBER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUND_NUMBER - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [WORD_SIZE-1:0] v0, v1;
    logic [WORD_SIZE-1:0] k0, k1, k2, k3;
    logic [WORD_SIZE-1:0] sum;
    logic [CNT_W-1:0]     cnt;

    logic [WORD_SIZE-1:0] sum_nx_c;
    logic [WORD_SIZE-1:0] v0_nx_c;
    logic [WORD_SIZE-1:0] v1_nx_c;
    logic                 run_c;
    logic                 last_c;

    // State register; reset always restarts in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave RUN on the edge that performs the final cycle.
    always_comb begin
        state_nx = state;
        if (state == S_RUN && last_c) begin
            state_nx = S_DONE;
        end
    end

    // One TEA cycle; v1 update uses the freshly computed v0.
    always_comb begin
        run_c    = (state == S_RUN);
        last_c   = run_c && (cnt == LAST_CNT);
        sum_nx_c = sum + DELTA;
        v0_nx_c  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_nx_c) ^ ((v1 >> 5) + k1));
        v1_nx_c  = v1 + (((v0_nx_c << 4) + k2) ^ (v0_nx_c + sum_nx_c) ^ ((v0_nx_c >> 5) + k3));
    end

    // Working registers, key latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0    <= iV0;
            v1    <= iV1;
            k0    <= iK0;
            k1    <= iK1;
            k2    <= iK2;
            k3    <= iK3;
            sum   <= '0;
            cnt   <= '0;
            oC0   <= '0;
            oC1   <= '0;
            oDone <= 1'b0;
        end else if (run_c) begin
            sum <= sum_nx_c;
            v0  <= v0_nx_c;
            v1  <= v1_nx_c;
            cnt <= cnt + CNT_W'(1);
            if (last_c) begin
                oC0   <= v0_nx_c;
                oC1   <= v1_nx_c;
                oDone <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cipher.sv
// Directed bench for the TEA core: default 32-cycle instance plus a
// single-cycle instance sharing clock, reset and inputs.
module tb_cipher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iV0 = '0, iV1 = '0;
    logic [31:0] iK0 = '0, iK1 = '0, iK2 = '0, iK3 = '0;
    logic [31:0] oC0, oC1, s_c0, s_c1;
    logic        oDone, s_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_edge;
    int s_done_edge;
    bit partial_ok;

    always #5 clk = ~clk;

    cipher u_dut (
        .clk(clk), .rst(rst),
        .iV0(iV0), .iV1(iV1),
        .iK0(iK0), .iK1(iK1), .iK2(iK2), .iK3(iK3),
        .oC0(oC0), .oC1(oC1), .oDone(oDone)
    );

    cipher #(.ROUND_NUMBER(1)) u_one (
        .clk(clk), .rst(rst),
        .iV0(iV0), .iV1(iV1),
        .iK0(iK0), .iK1(iK1), .iK2(iK2), .iK3(iK3),
        .oC0(s_c0), .oC1(s_c1), .oDone(s_done)
    );

    // Reference TEA encryption written as the classic C loop.
    function automatic logic [63:0] tea_ref(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] q0, input logic [31:0] q1,
                                            input logic [31:0] q2, input logic [31:0] q3);
        logic [31:0] y, z, s;
        y = a0; z = a1; s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            s = s + 32'h9e3779b9;
            y = y + (((z << 4) + q0) ^ (z + s) ^ ((z >> 5) + q1));
            z = z + (((y << 4) + q2) ^ (y + s) ^ ((y >> 5) + q3));
        end
        return {y, z};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] q0, input logic [31:0] q1,
                        input logic [31:0] q2, input logic [31:0] q3);
        iV0 = a0; iV1 = a1; iK0 = q0; iK1 = q1; iK2 = q2; iK3 = q3;
    endtask

    // Pulse reset for one edge and check the cleared outputs after it.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rst_out"}, {oC0, oC1}, 64'h0);
        check({tag, "_rst_done"}, {63'h0, oDone}, 64'h0);
        rst = 1'b0;
    endtask

    // Clock until completion (bounded); optionally scramble inputs meanwhile.
    task automatic wait_done(input bit scramble);
        done_edge   = -1;
        s_done_edge = -1;
        partial_ok  = 1'b1;
        for (int i = 1; i <= 40 && done_edge < 0; i++) begin
            @(posedge clk); #1;
            if (s_done && s_done_edge < 0) s_done_edge = i;
            if (oDone) done_edge = i;
            else if (oC0 !== 32'h0 || oC1 !== 32'h0) partial_ok = 1'b0;
            if (scramble) load($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
    endtask

    logic [63:0] exp_a, exp_b, res_a;
    bit          stable;

    initial begin
        // Zero vector on both instances.
        load('0, '0, '0, '0, '0, '0);
        do_reset("zero");
        wait_done(1'b0);
        check("zero_latency", 64'(done_edge), 64'd32);
        check("zero_partial", {63'h0, partial_ok}, 64'h1);
        check("zero_ct", {oC0, oC1}, 64'h41ea3a0a_94baa940);
        check("one_latency", 64'(s_done_edge), 64'd1);
        check("one_ct", {s_c0, s_c1}, 64'h9e3779b9_dbe8d32f);
        check("one_done", {63'h0, s_done}, 64'h1);

        // Directed vector against the reference model, then long hold.
        exp_a = tea_ref(32'h3d45f7a7, 32'h235fcb21,
                        32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235);
        load(32'h3d45f7a7, 32'h235fcb21, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235);
        do_reset("vecA");
        wait_done(1'b0);
        check("vecA_latency", 64'(done_edge), 64'd32);
        check("vecA_ct", {oC0, oC1}, exp_a);
        res_a  = {oC0, oC1};
        stable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ({oC0, oC1} !== res_a || oDone !== 1'b1) stable = 1'b0;
        end
        check("vecA_hold", {63'h0, stable}, 64'h1);

        // Same vector, inputs scrambled after release must not matter.
        load(32'h3d45f7a7, 32'h235fcb21, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235);
        do_reset("iso");
        wait_done(1'b1);
        check("iso_latency", 64'(done_edge), 64'd32);
        check("iso_ct", {oC0, oC1}, exp_a);

        // Mid-run reset with new inputs.
        exp_b = tea_ref(32'h01234567, 32'h89abcdef,
                        32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
        load(32'h3d45f7a7, 32'h235fcb21, 32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235);
        do_reset("mid0");
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        load(32'h01234567, 32'h89abcdef, 32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
        do_reset("mid");
        wait_done(1'b0);
        check("mid_latency", 64'(done_edge), 64'd32);
        check("mid_partial", {63'h0, partial_ok}, 64'h1);
        check("mid_ct", {oC0, oC1}, exp_b);

        // Reset while DONE clears everything on the next edge.
        do_reset("done");
        wait_done(1'b0);
        check("redo_ct", {oC0, oC1}, exp_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
